// File: rtl/div_arbiter.sv
// Round-robin front end that shares one multi-cycle signed Q16.16 divider among N_REQ requesters.
// Divide-by-zero is answered locally with a saturated quotient and never starts the divider.
module div_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_num,
    input  logic [N_REQ*WIDTH-1:0] req_den,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]       resp_quot,
    output logic                   resp_dz,
    output logic                   busy,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_num,
    output logic [WIDTH-1:0]       div_den,
    input  logic [WIDTH-1:0]       div_quot,
    input  logic                   div_finished
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Saturated results for x/0: largest positive, or most negative plus one so it stays symmetric
    localparam logic [WIDTH-1:0] DZ_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] DZ_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    cand;
    logic             gnt_any;
    logic [N_REQ-1:0] gnt_oh;
    logic             den_zero;
    int               pos;

    // First valid requester at or after rr_ptr, searching upward with wrap
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            cand = PW'(pos);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (state == S_RESP) resp_valid[owner] = 1'b1;
    end

    assign req_ready = (rst_n && state == S_IDLE) ? gnt_oh : '0;
    assign den_zero  = (div_den == '0);
    assign div_start = (state == S_ISSUE) && !den_zero;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            resp_quot <= '0;
            resp_dz   <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        div_num <= req_num[gnt_idx*WIDTH +: WIDTH];
                        div_den <= req_den[gnt_idx*WIDTH +: WIDTH];
                        owner   <= gnt_idx;
                        rr_ptr  <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (den_zero) begin
                        resp_quot <= div_num[WIDTH-1] ? DZ_NEG : DZ_POS;
                        resp_dz   <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (div_finished) begin
                        resp_quot <= div_quot;
                        resp_dz   <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
